serial_demux_ch: RTL and testbench



---
 rtl/serial_demux_ch.sv | 163 ++++++++++++++++
 tb/tb_serial_demux_ch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_demux_ch.sv
// Serial packet demultiplexer: start / address / length / data framing, data bits steered to NUM_CH channels.
// Optional trailing even-parity bit is enabled by defining SERIAL_DEMUX_PARITY_EN.
module serial_demux_ch #(
    parameter  int ADDR_W = 2,
    parameter  int LEN_W  = 4,
    localparam int NUM_CH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              ser_in,
    output logic [NUM_CH-1:0] p,
    output logic              ser_out_valid,
    output logic [ADDR_W-1:0] ch_sel,
    output logic [LEN_W-1:0]  rem_cnt,
    output logic              busy,
    output logic              done,
    output logic              parity_err,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd5;
`ifdef SERIAL_DEMUX_PARITY_EN
    localparam logic [2:0] S_PAR  = 3'd4;
    localparam logic [2:0] S_TAIL = S_PAR;
`else
    localparam logic [2:0] S_TAIL = S_DONE;
`endif

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_p;
    logic              r_valid;
    logic [ADDR_W-1:0] r_ch_sel;
    logic [LEN_W-1:0]  r_rem;
    logic              r_done;
    logic              r_perr;
`ifdef SERIAL_DEMUX_PARITY_EN
    logic              r_par;
    logic              r_perr_flag;
`endif

    logic [ADDR_W-1:0] w_addr_shift;
    logic [LEN_W-1:0]  w_len_shift;
    logic [NUM_CH-1:0] w_p_next;

    // Fields arrive MSB first, so each new bit enters at the LSB.
    assign w_addr_shift = ADDR_W'({r_ch_sel, ser_in});
    assign w_len_shift  = LEN_W'({r_rem, ser_in});

    always_comb begin
        w_p_next           = '0;
        w_p_next[r_ch_sel] = ser_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_p      <= '0;
            r_valid  <= 1'b0;
            r_ch_sel <= '0;
            r_rem    <= '0;
            r_done   <= 1'b0;
            r_perr   <= 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
            r_par       <= 1'b0;
            r_perr_flag <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clk_en && !ser_in) begin
                        r_state <= S_ADDR;
                        r_cnt   <= '0;
`ifdef SERIAL_DEMUX_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    if (clk_en) begin
                        r_ch_sel <= w_addr_shift;
                        if (r_cnt == ADDR_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_LEN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    if (clk_en) begin
                        r_rem <= w_len_shift;
                        if (r_cnt == LEN_LAST) begin
                            r_cnt <= '0;
                            // An empty packet leaves p untouched from the previous one.
                            if (w_len_shift == '0) begin
                                r_state <= S_TAIL;
                            end else begin
                                r_state <= S_DATA;
                                r_p     <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_en) begin
                        r_p     <= w_p_next;
                        r_valid <= 1'b1;
                        r_rem   <= r_rem - 1'b1;
`ifdef SERIAL_DEMUX_PARITY_EN
                        r_par   <= r_par ^ ser_in;
`endif
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= S_TAIL;
                        end
                    end
                end
`ifdef SERIAL_DEMUX_PARITY_EN
                S_PAR: begin
                    if (clk_en) begin
                        r_perr_flag <= r_par ^ ser_in;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // Leaves regardless of clk_en; the end-of-packet pulse lands on this edge.
                    r_done  <= 1'b1;
`ifdef SERIAL_DEMUX_PARITY_EN
                    r_perr  <= r_perr_flag;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p             = r_p;
    assign ser_out_valid = r_valid;
    assign ch_sel        = r_ch_sel;
    assign rem_cnt       = r_rem;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign parity_err    = r_perr;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_serial_demux_ch.sv
// Directed bench for serial_demux_ch: default 4-channel instance plus an ADDR_W=3/LEN_W=5 instance.
// Covers strobe gaps, zero-length packets, mid-packet reset and (with SERIAL_DEMUX_PARITY_EN) parity.
module tb_serial_demux_ch;

    logic clk = 1'b0;
    logic rst, clk_en, ser_in, clk_en_b, ser_in_b;

    logic [3:0] p;
    logic       ser_out_valid;
    logic [1:0] ch_sel;
    logic [3:0] rem_cnt;
    logic       busy, done, parity_err;
    logic [2:0] state_dbg;

    logic [7:0] p_b;
    logic       valid_b;
    logic [2:0] ch_sel_b;
    logic [4:0] rem_cnt_b;
    logic       busy_b, done_b, perr_b;
    logic [2:0] state_dbg_b;

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_done = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_p;
    logic [3:0] snap_rem;
    logic [1:0] snap_ch;

    always #5 clk = ~clk;

    serial_demux_ch dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_in),
        .p(p), .ser_out_valid(ser_out_valid), .ch_sel(ch_sel), .rem_cnt(rem_cnt),
        .busy(busy), .done(done), .parity_err(parity_err), .state_dbg(state_dbg)
    );

    serial_demux_ch #(.ADDR_W(3), .LEN_W(5)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en_b), .ser_in(ser_in_b),
        .p(p_b), .ser_out_valid(valid_b), .ch_sel(ch_sel_b), .rem_cnt(rem_cnt_b),
        .busy(busy_b), .done(done_b), .parity_err(perr_b), .state_dbg(state_dbg_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Scoreboard for instance A: every valid pulse must match the next queued p word.
    always @(posedge clk) begin
        #1;
        if (ser_out_valid === 1'b1) begin
            n_valid++;
            exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
            chk("p_word", 32'(p), 32'(exp_p));
        end
        if (done === 1'b1) n_done++;
    end

    // One bit on the wire: gap-1 idle clocks with clk_en low, then one strobed clock.
    task automatic step(input bit which, input logic b, input int gap);
        for (int k = 0; k < gap; k++) begin
            if (which) begin ser_in_b = b; clk_en_b = (k == gap - 1); end
            else       begin ser_in   = b; clk_en   = (k == gap - 1); end
            snap_rem = rem_cnt;
            snap_ch  = ch_sel;
            @(posedge clk); #1;
            if (!which && k != gap - 1) begin
                chk("hold_rem", 32'(rem_cnt), 32'(snap_rem));
                chk("hold_ch", 32'(ch_sel), 32'(snap_ch));
                chk("gap_valid", 32'(ser_out_valid), 32'd0);
            end
        end
    endtask

    task automatic send_hdr(input bit which, input int aw, input int lw, input int addr,
                            input int len, input int gap);
        step(which, 1'b0, gap);
        for (int i = aw - 1; i >= 0; i--) step(which, addr[i], gap);
        for (int i = lw - 1; i >= 0; i--) step(which, len[i], gap);
    endtask

    task automatic finish_pkt(input bit which, input logic exp_perr);
        chk("done_early", 32'(which ? done_b : done), 32'd0);
        chk("busy_in_done", 32'(which ? busy_b : busy), 32'd1);
        if (which) begin clk_en_b = 1'b0; ser_in_b = 1'b1; end
        else       begin clk_en   = 1'b0; ser_in   = 1'b1; end
        @(posedge clk); #1;
        chk("done", 32'(which ? done_b : done), 32'd1);
        chk("parity_err", 32'(which ? perr_b : parity_err), 32'(exp_perr));
        chk("busy_idle", 32'(which ? busy_b : busy), 32'd0);
        @(posedge clk); #1;
        chk("done_width", 32'(which ? done_b : done), 32'd0);
    endtask

    task automatic send_a_pkt(input int addr, input int len, input logic [15:0] data,
                              input int gap, input logic flip);
        logic par;
        logic eperr;
        par = 1'b0;
        eperr = 1'b0;
        send_hdr(0, 2, 4, addr, len, gap);
        chk("hdr_rem", 32'(rem_cnt), 32'(len));
        chk("hdr_ch", 32'(ch_sel), 32'(addr));
        for (int i = len - 1; i >= 0; i--) begin
            exp_q.push_back(data[i] ? 4'(1 << addr) : 4'd0);
            par = par ^ data[i];
            step(0, data[i], gap);
            chk("rem_cnt", 32'(rem_cnt), 32'(i));
            chk("ch_sel", 32'(ch_sel), 32'(addr));
        end
`ifdef SERIAL_DEMUX_PARITY_EN
        step(0, par ^ flip, gap);
        eperr = flip;
`else
        eperr = flip & 1'b0;
`endif
        finish_pkt(0, eperr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] dat_b;
        rst = 1'b1; clk_en = 1'b0; ser_in = 1'b1; clk_en_b = 1'b0; ser_in_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_p", 32'(p), 32'd0);
        chk("rst_valid", 32'(ser_out_valid), 32'd0);
        chk("rst_ch", 32'(ch_sel), 32'd0);
        chk("rst_rem", 32'(rem_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);

        // Idle line high: must stay idle.
        step(0, 1'b1, 1);
        step(0, 1'b1, 1);
        chk("idle_busy", 32'(busy), 32'd0);

        // 0,10,0011,101 with a strobe every clock, then every third clock.
        send_a_pkt(2, 3, 16'b101, 1, 1'b0);
        chk("pkt1_p", 32'(p), 32'h4);
        send_a_pkt(2, 3, 16'b101, 3, 1'b0);
        chk("pkt2_p", 32'(p), 32'h4);

        // Empty packet, then an immediate next packet.
        send_a_pkt(1, 0, 16'd0, 1, 1'b0);
        chk("len0_p_kept", 32'(p), 32'h4);
        chk("len0_ch", 32'(ch_sel), 32'd1);
        send_a_pkt(3, 2, 16'b11, 1, 1'b0);
        chk("pkt4_p", 32'(p), 32'h8);

        // Reset after 2 of 5 data bits.
        send_hdr(0, 2, 4, 0, 5, 1);
        exp_q.push_back(4'b0001); step(0, 1'b1, 1);
        exp_q.push_back(4'b0000); step(0, 1'b0, 1);
        chk("mid_rem", 32'(rem_cnt), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_p", 32'(p), 32'd0);
        chk("mrst_valid", 32'(ser_out_valid), 32'd0);
        chk("mrst_ch", 32'(ch_sel), 32'd0);
        chk("mrst_rem", 32'(rem_cnt), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst = 1'b0; clk_en = 1'b0;
        @(posedge clk); #1;
        chk("mrst_no_done", 32'(done), 32'd0);
        send_a_pkt(1, 4, 16'b1001, 1, 1'b0);
        chk("fresh_p", 32'(p), 32'h2);

`ifdef SERIAL_DEMUX_PARITY_EN
        send_a_pkt(2, 3, 16'b101, 1, 1'b1);
        chk("valid_total", 32'(n_valid), 32'd17);
        chk("done_total", 32'(n_done), 32'd6);
`else
        chk("valid_total", 32'(n_valid), 32'd14);
        chk("done_total", 32'(n_done), 32'd5);
`endif
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // Wide build: channel 7, 17 data bits.
        dat_b = 17'h169C5;
        send_hdr(1, 3, 5, 7, 17, 1);
        chk("b_hdr_rem", 32'(rem_cnt_b), 32'd17);
        chk("b_hdr_ch", 32'(ch_sel_b), 32'd7);
        for (int i = 16; i >= 0; i--) begin
            step(1, dat_b[i], 1);
            chk("b_valid", 32'(valid_b), 32'd1);
            chk("b_p", 32'(p_b), dat_b[i] ? 32'h80 : 32'h0);
            chk("b_rem", 32'(rem_cnt_b), 32'(i));
        end
`ifdef SERIAL_DEMUX_PARITY_EN
        step(1, ^dat_b, 1);
`endif
        finish_pkt(1, 1'b0);
        chk("b_valid_clear", 32'(valid_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
